// File: rtl/mips_mem_pkg.sv
// Shared encodings, state type and request record for the MIPS load/store unit.
// Pure declarations: no latency and no flow control of its own.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;

  typedef struct packed {
    logic        store;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [1:0]  off;
    logic [31:0] wdata;
  } lsu_req_t;

  // Reserved size 2'b10 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic is_subword(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Big-endian lane select/extend for loads and lane merge for sub-word stores.
// Purely combinational, zero latency; no flow control.
module lsu_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (off)
      2'd0: byte_lane = word[31:24];
      2'd1: byte_lane = word[23:16];
      2'd2: byte_lane = word[15:8];
      2'd3: byte_lane = word[7:0];
      default: byte_lane = 8'h00;
    endcase
    half_lane = off[1] ? word[15:0] : word[31:16];

    case (size)
      SZ_BYTE: load_data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      SZ_HALF: load_data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
      default: load_data = word;
    endcase

    // Offset 0 is the most significant byte of the word.
    store_word = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0: store_word[31:24] = wdata[7:0];
          2'd1: store_word[23:16] = wdata[7:0];
          2'd2: store_word[15:8]  = wdata[7:0];
          2'd3: store_word[7:0]   = wdata[7:0];
          default: store_word = word;
        endcase
      end
      SZ_HALF: begin
        if (off[1]) store_word[15:0]  = wdata[15:0];
        else        store_word[31:16] = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// One-at-a-time load/store sequencer in front of a fixed-latency word memory.
// Latency MEM_WAIT+1 (load/word store), 2*MEM_WAIT+1 (sub-word store), 1 (misaligned); req_ready low while busy.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MEM_WAIT + 1);

  generate
    if (MEM_WAIT < 1) begin : g_bad_wait
      $error("load_store_unit: MEM_WAIT must be at least 1");
    end
  endgenerate

  lsu_state_t    state;
  logic [CW-1:0] cnt;
  lsu_req_t      req_q;
  logic [31:0]   load_data;
  logic [31:0]   store_word;

  assign req_ready = (state == IDLE);

  lsu_align u_align (
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .off         (req_q.off),
    .word        (mem_rdata),
    .wdata       (req_q.wdata),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      req_q          <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_misalign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q <= '{store: req_store, size: req_size, is_unsigned: req_unsigned,
                       off: req_addr[1:0], wdata: req_wdata};
            cnt   <= CW'(MEM_WAIT - 1);
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
              resp_rdata    <= '0;
            end else begin
              mem_address <= {req_addr[31:2], 2'b00};
              // Word stores skip the read; sub-word stores need the old word first.
              if (req_store && !is_subword(req_size)) begin
                state          <= WR;
                mem_write      <= 1'b1;
                mem_write_data <= req_wdata;
              end else begin
                state    <= RD;
                mem_read <= 1'b1;
              end
            end
          end
        end
        RD: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            mem_read <= 1'b0;
            if (req_q.store) begin
              state          <= WR;
              mem_write      <= 1'b1;
              mem_write_data <= store_word;
              cnt            <= CW'(MEM_WAIT - 1);
            end else begin
              state       <= RESP;
              mem_address <= '0;
              resp_valid  <= 1'b1;
              resp_rdata  <= load_data;
            end
          end
        end
        WR: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state          <= RESP;
            mem_write      <= 1'b0;
            mem_write_data <= '0;
            mem_address    <= '0;
            resp_valid     <= 1'b1;
            resp_rdata     <= '0;
          end
        end
        RESP: begin
          state         <= IDLE;
          resp_valid    <= 1'b0;
          resp_rdata    <= '0;
          resp_misalign <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage sitting directly upstream of the MIPS data memory. It takes one load/store request at a time from the execute/memory pipeline stage and converts it into word-aligned `mem_read`/`mem_write` transactions. It also performs big-endian byte/halfword lane selection, sign/zero extension, read-modify-write for sub-word stores, and alignment checking. A wait counter covers the memory's fixed access latency, and `req_ready` serves as the pipeline stall.

## Interface
Parameters:
- `MEM_WAIT`, default 2: number of cycles one memory read or write occupies. Must be ≥1; 0 is an elaboration error.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle; a request is accepted on a posedge where `req_valid && req_ready`.
- `req_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 11 word; 10 is reserved and treated as word.
- `req_unsigned` in 1: zero-extend on load (LBU/LHU); ignored for stores and words.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and misaligned accesses.
- `resp_misalign` out 1: valid with `resp_valid`; set when the address is misaligned.
- `mem_address` out 32: word-aligned address, `{req_addr[31:2],2'b00}`.
- `mem_write_data` out 32: full word to write.
- `mem_read` out 1: read strobe.
- `mem_write` out 1: write strobe; the memory writes on posedge.
- `mem_rdata` in 32: memory read data, big-endian (byte offset 0 = bits [31:24]).

## Operation
- The request fields are latched at acceptance. Inputs are ignored in every state except IDLE.
- Misalignment rules: halfword with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - Transition IDLE→RESP with `resp_misalign=1` and `resp_rdata=0`.
  - No memory strobe is issued.
- States:
  - IDLE: `req_ready=1`. Accepted misaligned request → RESP. Load or sub-word store → RD. Word store → WR.
  - RD: `mem_read=1` for exactly `MEM_WAIT` cycles. `mem_rdata` is captured on the final RD posedge. Load → RESP; sub-word store → WR.
  - WR: `mem_write=1` for exactly `MEM_WAIT` cycles with address and data held stable (the repeated write is idempotent) → RESP.
  - RESP: `resp_valid=1` for one cycle → IDLE.
- Load lane select, with byte offset k = `addr[1:0]`:
  - Byte: `word[31-8k -: 8]`.
  - Halfword: offset 0 → [31:16], offset 2 → [15:0].
  - Result is sign-extended unless `req_unsigned`.
- Sub-word store merge: replace only the addressed lane of the captured word with `wdata[7:0]` or `wdata[15:0]`. Other lanes are unchanged.
- Word store: `mem_write_data = wdata`.
- `mem_address`, `mem_write_data`, `mem_read` and `mem_write` are registered. They are 0 in IDLE and RESP.
- Wait counter width is `$clog2(MEM_WAIT+1)`. It loads `MEM_WAIT-1` on entry to RD or WR and the state exits at 0. There is no wrap.

## Timing
- Let cycle 0 be the accept posedge.
- Load: `mem_read` high in cycles 1..MEM_WAIT; `resp_valid` in cycle MEM_WAIT+1.
- Word store: `mem_write` high in cycles 1..MEM_WAIT; `resp_valid` in cycle MEM_WAIT+1.
- Sub-word store: RD in cycles 1..MEM_WAIT; WR in cycles MEM_WAIT+1..2·MEM_WAIT; `resp_valid` in cycle 2·MEM_WAIT+1.
- Misaligned request: `resp_valid` in cycle 1.
- `req_ready` returns in the cycle after RESP. The minimum spacing between accepts is latency+1, and there is no back-to-back overlap.
- Reset values: state IDLE; `req_ready=1`; `resp_valid=0`, `resp_rdata=0`, `resp_misalign=0`; all `mem_*` outputs 0.
- Reset mid-operation: all outputs go to reset values immediately and no response is issued. If reset arrives during RD of a sub-word store, memory is not written. If it arrives during WR, the write may or may not complete.

## Structure
- Package `mips_mem_pkg` holds:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - state enum `lsu_state_t` {IDLE, RD, WR, RESP};
  - misalignment predicate function.
- Sub-module `lsu_align` (combinational) contains the load extract/extend and store merge logic. It is the only lane-mapping code.

## Test plan
All scenarios use `MEM_WAIT=2`. Word 0x10 is preloaded with 0x8899AABB.
1. LB 0x11 signed → `resp_rdata=0xFFFFFF99` in cycle 3; `mem_address=0x10` and `mem_read=1` in cycles 1–2.
2. LHU 0x12 → 0x0000AABB; LH 0x10 → 0xFFFF8899; LW 0x10 → 0x8899AABB.
3. SB 0x13 with `wdata=0x123456CC` → `mem_read` in cycles 1–2, `mem_write` in cycles 3–4 with `mem_write_data=0x8899AACC`, `resp_valid` in cycle 5. A following LW 0x10 returns 0x8899AACC.
4. LW 0x12 → `resp_valid` and `resp_misalign` in cycle 1, `resp_rdata=0`, no `mem_*` strobe; SH 0x11 behaves the same.
5. Deassert `rst_n` during RD of SH 0x10 → all outputs 0 asynchronously, word 0x10 unchanged, `req_ready=1` after release, no `resp_valid`.
6. Hold `req_valid` with two loads queued → the second is accepted on the posedge after RESP. `req_ready=0` throughout the first request, and the first request's fields are unaffected by input changes.
